// File: rtl/pkt_frame_tracker.sv
// Packet frame tracker: watches the ingress valid/ready/last handshake and
// produces sop/eop pulses for a set-priority "packet in progress" flag, plus
// packet length and runt/oversize/timeout indications.
module pkt_frame_tracker #(
   parameter int unsigned MIN_BEATS      = 8,
   parameter int unsigned MAX_BEATS      = 190,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_ready,
   input  logic             in_last,
   output logic             sop_pulse,
   output logic             eop_pulse,
   output logic             busy,
   output logic [CNT_W-1:0] beat_count,
   output logic [CNT_W-1:0] pkt_len,
   output logic             len_valid,
   output logic             err_runt,
   output logic             err_oversize,
   output logic             err_timeout
);

   localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_BEATS);
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
   localparam logic             RUNT_ONE = (MIN_BEATS > 32'd1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACTIVE   = 2'd1,
      EOP_PEND = 2'd2,
      DISCARD  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [CNT_W-1:0] pkt_len_q, pkt_len_d;
   logic             sop_q, sop_d;
   logic             eop_q, eop_d;
   logic             len_valid_q, len_valid_d;
   logic             runt_q, runt_d;
   logic             ovs_q, ovs_d;
   logic             tmo_q, tmo_d;
   logic             busy_q, busy_d;

   logic             beat;
   logic [CNT_W-1:0] beat_inc;
   logic [CNT_W-1:0] idle_inc;

   // Next-state, counter and registered-output computation
   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      idle_cnt_d  = '0;
      pkt_len_d   = pkt_len_q;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
      len_valid_d = 1'b0;
      runt_d      = 1'b0;
      ovs_d       = 1'b0;
      tmo_d       = 1'b0;

      beat     = in_valid & in_ready;
      beat_inc = beat_cnt_q + ONE_C;
      idle_inc = idle_cnt_q + ONE_C;

      case (state_q)
         IDLE: begin
            if (beat) begin
               sop_d      = 1'b1;
               beat_cnt_d = ONE_C;
               state_d    = in_last ? EOP_PEND : ACTIVE;
            end
         end

         // Deferred end of a single-beat packet so sop and eop never coincide
         EOP_PEND: begin
            eop_d       = 1'b1;
            len_valid_d = 1'b1;
            pkt_len_d   = ONE_C;
            runt_d      = RUNT_ONE;
            beat_cnt_d  = '0;
            state_d     = IDLE;
            if (beat) begin
               sop_d      = 1'b1;
               beat_cnt_d = ONE_C;
               state_d    = in_last ? EOP_PEND : ACTIVE;
            end
         end

         ACTIVE: begin
            if (beat) begin
               if (in_last) begin
                  eop_d       = 1'b1;
                  len_valid_d = 1'b1;
                  pkt_len_d   = beat_inc;
                  runt_d      = (beat_inc < MIN_C);
                  beat_cnt_d  = '0;
                  state_d     = IDLE;
               end else if (beat_inc == MAX_C) begin
                  eop_d       = 1'b1;
                  len_valid_d = 1'b1;
                  ovs_d       = 1'b1;
                  pkt_len_d   = MAX_C;
                  beat_cnt_d  = beat_inc;
                  state_d     = DISCARD;
               end else begin
                  beat_cnt_d = beat_inc;
               end
            end else begin
               idle_cnt_d = idle_inc;
               if (idle_inc == TMO_C) begin
                  eop_d       = 1'b1;
                  len_valid_d = 1'b1;
                  tmo_d       = 1'b1;
                  pkt_len_d   = beat_cnt_q;
                  idle_cnt_d  = '0;
                  state_d     = DISCARD;
               end
            end
         end

         // Drop the remainder of an aborted packet without any pulses
         DISCARD: begin
            if (beat) begin
               if (in_last) begin
                  beat_cnt_d = '0;
                  state_d    = IDLE;
               end
            end else begin
               idle_cnt_d = idle_inc;
               if (idle_inc == TMO_C) begin
                  idle_cnt_d = '0;
                  beat_cnt_d = '0;
                  state_d    = IDLE;
               end
            end
         end

         default: begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, counters and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         idle_cnt_q  <= '0;
         pkt_len_q   <= '0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         len_valid_q <= 1'b0;
         runt_q      <= 1'b0;
         ovs_q       <= 1'b0;
         tmo_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         pkt_len_q   <= pkt_len_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         len_valid_q <= len_valid_d;
         runt_q      <= runt_d;
         ovs_q       <= ovs_d;
         tmo_q       <= tmo_d;
         busy_q      <= busy_d;
      end
   end

   assign sop_pulse    = sop_q;
   assign eop_pulse    = eop_q;
   assign busy         = busy_q;
   assign beat_count   = beat_cnt_q;
   assign pkt_len      = pkt_len_q;
   assign len_valid    = len_valid_q;
   assign err_runt     = runt_q;
   assign err_oversize = ovs_q;
   assign err_timeout  = tmo_q;

endmodule

// File: tb/tb_pkt_frame_tracker.sv
// Directed bench for pkt_frame_tracker with default parameters.
module tb_pkt_frame_tracker;

   localparam int unsigned CNT_W = 16;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic             sop_pulse;
   logic             eop_pulse;
   logic             busy;
   logic [CNT_W-1:0] beat_count;
   logic [CNT_W-1:0] pkt_len;
   logic             len_valid;
   logic             err_runt;
   logic             err_oversize;
   logic             err_timeout;

   int checks = 0;
   int errors = 0;

   pkt_frame_tracker #(
      .MIN_BEATS      (8),
      .MAX_BEATS      (190),
      .TIMEOUT_CYCLES (1024),
      .CNT_W          (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_last      (in_last),
      .sop_pulse    (sop_pulse),
      .eop_pulse    (eop_pulse),
      .busy         (busy),
      .beat_count   (beat_count),
      .pkt_len      (pkt_len),
      .len_valid    (len_valid),
      .err_runt     (err_runt),
      .err_oversize (err_oversize),
      .err_timeout  (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {sop, eop, len_valid, runt, oversize, timeout}
   function automatic logic [5:0] pulses();
      return {sop_pulse, eop_pulse, len_valid, err_runt, err_oversize, err_timeout};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the capturing edge
   task automatic step(input logic v, input logic r, input logic l);
      in_valid = v;
      in_ready = r;
      in_last  = l;
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid = 1'b0;
      in_ready = 1'b0;
      in_last  = 1'b0;
      reset    = 1'b1;
      #1 reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_pulses", 32'(pulses()), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_cnt", 32'(beat_count), 32'h0);
      chk("reset_len", 32'(pkt_len), 32'h0);
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0);

      // 1: ten back-to-back beats, last on beat 10
      step(1'b1, 1'b1, 1'b0);
      chk("t1_sop", 32'(pulses()), 32'h20);
      chk("t1_busy", 32'(busy), 32'h1);
      chk("t1_cnt1", 32'(beat_count), 32'd1);
      for (int i = 2; i <= 9; i++) step(1'b1, 1'b1, 1'b0);
      chk("t1_mid_pulses", 32'(pulses()), 32'h0);
      chk("t1_cnt9", 32'(beat_count), 32'd9);
      step(1'b1, 1'b1, 1'b1);
      chk("t1_eop", 32'(pulses()), 32'h18);
      chk("t1_len", 32'(pkt_len), 32'd10);
      chk("t1_cnt_clr", 32'(beat_count), 32'd0);
      chk("t1_busy_clr", 32'(busy), 32'h0);
      step(1'b0, 1'b0, 1'b0);
      chk("t1_quiet", 32'(pulses()), 32'h0);

      // 2: single-beat packet, new packet on the very next cycle
      step(1'b1, 1'b1, 1'b1);
      chk("t2_sop", 32'(pulses()), 32'h20);
      chk("t2_busy", 32'(busy), 32'h1);
      step(1'b1, 1'b1, 1'b0);
      chk("t2_sop_eop_runt", 32'(pulses()), 32'h3C);
      chk("t2_len", 32'(pkt_len), 32'd1);
      chk("t2_cnt", 32'(beat_count), 32'd1);

      // 3: finish that second packet at 5 beats -> runt
      for (int i = 2; i <= 4; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("t3_noready_cnt", 32'(beat_count), 32'd4);
      step(1'b1, 1'b1, 1'b1);
      chk("t3_runt", 32'(pulses()), 32'h1C);
      chk("t3_len", 32'(pkt_len), 32'd5);
      step(1'b0, 1'b0, 1'b0);

      // 4: 200 beats without last until beat 200 -> oversize at 190
      for (int i = 1; i <= 200; i++) begin
         step(1'b1, 1'b1, (i == 200));
         if (i == 189) chk("t4_no_early_ovs", 32'(pulses()), 32'h0);
         if (i == 190) begin
            chk("t4_ovs", 32'(pulses()), 32'h1A);
            chk("t4_len", 32'(pkt_len), 32'd190);
            chk("t4_cnt_hold", 32'(beat_count), 32'd190);
         end
         if (i > 190) chk("t4_discard_quiet", 32'(pulses()), 32'h0);
         if (i == 199) chk("t4_discard_busy", 32'(busy), 32'h1);
      end
      chk("t4_busy_clr", 32'(busy), 32'h0);
      chk("t4_cnt_clr", 32'(beat_count), 32'd0);

      // 4b: exactly MAX_BEATS with last on the final beat is a normal end
      for (int i = 1; i <= 190; i++) step(1'b1, 1'b1, (i == 190));
      chk("t4b_normal_end", 32'(pulses()), 32'h18);
      chk("t4b_len", 32'(pkt_len), 32'd190);

      // 5: three beats then stall with valid high, ready low -> timeout
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 1'b0);
      for (int j = 1; j <= 1024; j++) begin
         step(1'b1, 1'b0, 1'b0);
         if (j == 1023) chk("t5_no_early_tmo", 32'(pulses()), 32'h0);
      end
      chk("t5_tmo", 32'(pulses()), 32'h19);
      chk("t5_len", 32'(pkt_len), 32'd3);
      chk("t5_busy", 32'(busy), 32'h1);
      step(1'b1, 1'b1, 1'b0);
      chk("t5_discard_beat", 32'(pulses()), 32'h0);
      chk("t5_discard_cnt", 32'(beat_count), 32'd3);
      // DISCARD also exits silently after a full idle timeout
      for (int j = 1; j <= 1024; j++) begin
         step(1'b0, 1'b0, 1'b0);
         if (j == 1023) chk("t5_discard_stay", 32'(busy), 32'h1);
         if (j == 1024) chk("t5_discard_exit_quiet", 32'(pulses()), 32'h0);
      end
      chk("t5_discard_exit", 32'(busy), 32'h0);

      // 5b: a beat clears the idle counter, so two 1023-cycle stalls never time out
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int j = 1; j <= 1023; j++) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("t5b_no_tmo1", 32'(pulses()), 32'h0);
      for (int j = 1; j <= 1023; j++) step(1'b1, 1'b0, 1'b0);
      chk("t5b_no_tmo2", 32'(pulses()), 32'h0);
      step(1'b1, 1'b1, 1'b1);
      chk("t5b_eop", 32'(pulses()), 32'h1C);
      chk("t5b_len", 32'(pkt_len), 32'd4);

      // 6: asynchronous reset mid-packet
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 1'b0);
      chk("t6_pre_cnt", 32'(beat_count), 32'd3);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_busy", 32'(busy), 32'h0);
      chk("t6_async_cnt", 32'(beat_count), 32'd0);
      chk("t6_async_len", 32'(pkt_len), 32'd0);
      chk("t6_async_pulses", 32'(pulses()), 32'h0);
      in_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      chk("t6_sop", 32'(pulses()), 32'h20);
      chk("t6_cnt", 32'(beat_count), 32'd1);
      step(1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
